// File: rtl/muldiv_unit_pkg.sv
// Shared opcodes, FSM encodings and helpers for the iterative multiply/divide unit.
package muldiv_unit_pkg;

  localparam int unsigned MdopWidth = 3;

  typedef logic [MdopWidth-1:0] mdop_t;

  localparam mdop_t MdopMult  = 3'd0;
  localparam mdop_t MdopMultu = 3'd1;
  localparam mdop_t MdopDiv   = 3'd2;
  localparam mdop_t MdopDivu  = 3'd3;
  localparam mdop_t MdopMthi  = 3'd4;
  localparam mdop_t MdopMtlo  = 3'd5;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StFix  = 2'd2;

  function automatic logic is_signed_op(mdop_t op);
    return (op == MdopMult) || (op == MdopDiv);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Pipeline-facing request/response bundle of the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  import muldiv_unit_pkg::*;

  logic             start;
  mdop_t            op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, abort,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, abort,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] work_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] work_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] diff;

  always_comb begin
    sum  = {1'b0, work_i[2*WIDTH-1:WIDTH]} + (work_i[0] ? {1'b0, opnd_i} : '0);
    // Remainder shifted left by one needs WIDTH+1 bits; the extra MSB is the borrow.
    diff = {1'b0, work_i[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd_i};
    if (is_div_i) begin
      if (!diff[WIDTH+1]) begin
        work_o = {diff[WIDTH-1:0], work_i[WIDTH-2:0], 1'b1};
      end else begin
        work_o = {work_i[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      work_o = {sum, work_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO; fixed WIDTH+1 cycle busy window.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          nrst,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_t             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d, work_step;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, a_neg_q, a_neg_d;
  logic               b_zero_q, b_zero_d, busy_q, busy_d, done_q, done_d;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;

  muldiv_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .work_i  (work_q),
    .opnd_i  (opnd_q),
    .is_div_i(is_div_q),
    .work_o  (work_step)
  );

  always_comb begin
    a_neg = is_signed_op(bus.op) & bus.a[WIDTH-1];
    b_neg = is_signed_op(bus.op) & bus.b[WIDTH-1];
    mag_a = a_neg ? -bus.a : bus.a;
    mag_b = b_neg ? -bus.b : bus.b;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    b_zero_d = b_zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.op)
            MdopMthi: hi_d = bus.a;
            MdopMtlo: lo_d = bus.a;
            MdopMult, MdopMultu, MdopDiv, MdopDivu: begin
              is_div_d = (bus.op == MdopDiv) || (bus.op == MdopDivu);
              neg_d    = a_neg ^ b_neg;
              a_neg_d  = a_neg;
              b_zero_d = (bus.b == '0);
              a_raw_d  = bus.a;
              work_d   = {{WIDTH{1'b0}}, mag_a};
              opnd_d   = mag_b;
              cnt_d    = CntW'(WIDTH - 1);
              busy_d   = 1'b1;
              state_d  = StRun;
            end
            default: ;
          endcase
        end
      end
      StRun: begin
        work_d = work_step;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_q ? -work_q : work_q;
        end else if (b_zero_q) begin
          lo_d = '1;
          hi_d = a_raw_q;
        end else begin
          lo_d = neg_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
          hi_d = a_neg_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Flush outranks the FIX write; it only matters once an operation is in flight.
    if (state_q != StIdle && bus.abort) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      work_q   <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      opnd_q   <= opnd_d;
      a_raw_q  <= a_raw_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      b_zero_q <= b_zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_pass;

  muldiv_unit_if #(.WIDTH(32)) bus32 ();
  muldiv_unit_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(
    .WIDTH(32)
  ) u_dut32 (
    .clk (clk),
    .nrst(nrst),
    .bus (bus32)
  );

  muldiv_unit #(
    .WIDTH(8)
  ) u_dut8 (
    .clk (clk),
    .nrst(nrst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit narrow, input logic start, input mdop_t op,
                       input logic [31:0] a, input logic [31:0] b, input logic abort);
    if (narrow) begin
      bus8.start = start; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0]; bus8.abort = abort;
    end else begin
      bus32.start = start; bus32.op = op; bus32.a = a; bus32.b = b; bus32.abort = abort;
    end
  endtask

  // Issue one op and follow it until done (or 60 cycles). Cycle c is sampled #1 after
  // the c-th edge following the start edge. Optional stray start / abort injections.
  task automatic run_op(input bit narrow, input mdop_t op, input logic [31:0] a,
                        input logic [31:0] b, input bit abort_at_start, input int inj_c,
                        input int abort_c, output logic [31:0] hi, output logic [31:0] lo,
                        output int busy_n, output int done_c);
    logic bsy, dn;
    @(negedge clk);
    drive(narrow, 1'b1, op, a, b, abort_at_start);
    @(posedge clk);
    #1;
    drive(narrow, 1'b0, op, a, b, 1'b0);
    busy_n = 0;
    done_c = 0;
    for (int c = 1; c <= 60; c++) begin
      bsy = narrow ? bus8.busy : bus32.busy;
      dn  = narrow ? bus8.done : bus32.done;
      if (bsy) busy_n++;
      if (dn) begin
        done_c = c;
        break;
      end
      drive(narrow, (c == inj_c), (c == inj_c) ? MdopMultu : op, (c == inj_c) ? 32'd3 : a,
            (c == inj_c) ? 32'd3 : b, (c == abort_c));
      @(posedge clk);
      #1;
    end
    drive(narrow, 1'b0, op, a, b, 1'b0);
    hi = narrow ? {24'b0, bus8.hi} : bus32.hi;
    lo = narrow ? {24'b0, bus8.lo} : bus32.lo;
  endtask

  typedef struct {
    string       name;
    bit          narrow;
    mdop_t       op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          done_c;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] hi, lo;
  int          busy_n, done_c, seen;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    nrst     = 1'b0;
    drive(1'b0, 1'b0, MdopMult, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, MdopMult, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hi", bus32.hi, 0);
    check_eq("rst_lo", bus32.lo, 0);
    check_eq("rst_busy", bus32.busy, 0);
    check_eq("rst_done", bus32.done, 0);
    @(negedge clk);
    nrst = 1'b1;

    vecs.push_back('{"multu_max", 0, MdopMultu, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFE, 32'h00000001, 34});
    vecs.push_back('{"mult_neg", 0, MdopMult, 32'hFFFFFFFD, 32'd7,
                     32'hFFFFFFFF, 32'hFFFFFFEB, 34});
    foreach (vecs[i]) begin
      run_op(vecs[i].narrow, vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, 0, hi, lo, busy_n, done_c);
      check_eq({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      check_eq({vecs[i].name, "_lo"}, lo, vecs[i].lo);
      check_eq({vecs[i].name, "_done_cyc"}, done_c, vecs[i].done_c);
      if (i == 0) check_eq("multu_busy_cycles", busy_n, 33);
    end

    // MTHI takes effect at the start edge with no busy window.
    @(negedge clk);
    drive(1'b0, 1'b1, MdopMthi, 32'h12345678, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, MdopMult, 32'd0, 32'd0, 1'b0);
    check_eq("mthi_hi", bus32.hi, 32'h12345678);
    check_eq("mthi_lo", bus32.lo, 32'hFFFFFFEB);
    check_eq("mthi_busy", bus32.busy, 0);
    @(posedge clk);
    #1;
    check_eq("mthi_done", bus32.done, 0);

    vecs.delete();
    vecs.push_back('{"div_neg", 0, MdopDiv, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34});
    vecs.push_back('{"div_ovf", 0, MdopDiv, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 34});
    vecs.push_back('{"divu_zero", 0, MdopDivu, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 34});
    vecs.push_back('{"div_zero", 0, MdopDiv, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 34});
    vecs.push_back('{"w8_mult", 1, MdopMult, 32'h80, 32'h80, 32'h40, 32'h00, 10});
    vecs.push_back('{"w8_div_ovf", 1, MdopDiv, 32'h80, 32'hFF, 32'h00, 32'h80, 10});
    foreach (vecs[i]) begin
      run_op(vecs[i].narrow, vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, 0, hi, lo, busy_n, done_c);
      check_eq({vecs[i].name, "_hi"}, hi, vecs[i].hi);
      check_eq({vecs[i].name, "_lo"}, lo, vecs[i].lo);
      check_eq({vecs[i].name, "_done_cyc"}, done_c, vecs[i].done_c);
    end
    check_eq("w8_busy_cycles", busy_n, 9);

    // A second start while busy must not disturb the running divide.
    run_op(0, MdopDivu, 32'd100, 32'd7, 0, 5, 0, hi, lo, busy_n, done_c);
    check_eq("divu_inj_lo", lo, 14);
    check_eq("divu_inj_hi", hi, 2);
    check_eq("divu_inj_done_cyc", done_c, 34);
    check_eq("divu_inj_busy", busy_n, 33);

    // Abort at cycle 10: no done, HI/LO keep the divide result.
    run_op(0, MdopMultu, 32'h10, 32'h10, 0, 0, 10, hi, lo, busy_n, done_c);
    check_eq("abort_no_done", done_c, 0);
    check_eq("abort_busy_cycles", busy_n, 10);
    check_eq("abort_hi", hi, 2);
    check_eq("abort_lo", lo, 14);

    // Abort alongside start in IDLE is a no-op, so the multiply runs.
    run_op(0, MdopMultu, 32'd6, 32'd7, 1, 0, 0, hi, lo, busy_n, done_c);
    check_eq("start_abort_lo", lo, 42);
    check_eq("start_abort_hi", hi, 0);
    check_eq("start_abort_done_cyc", done_c, 34);

    // Synchronous reset mid-operation.
    @(negedge clk);
    drive(1'b0, 1'b1, MdopMultu, 32'd5, 32'd5, 1'b0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, MdopMultu, 32'd0, 32'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    nrst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_hi", bus32.hi, 0);
    check_eq("midrst_lo", bus32.lo, 0);
    check_eq("midrst_busy", bus32.busy, 0);
    check_eq("midrst_done", bus32.done, 0);
    nrst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus32.done || bus32.busy) seen++;
    end
    check_eq("midrst_quiet", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
